// File: rtl/simple_alu_exec_if.sv
// Issue / write-back bundle for the single-cycle ALU execution unit.
// The master drives issue and grant signals (issue queue plus write-back
// arbiter). The slave is the execution unit itself.
interface simple_alu_exec_if #(
  parameter int PREG_W = 6,
  parameter int ROB_W  = 6
);
  logic              flush;
  logic              issue_valid;
  logic              fu_ready;
  logic [3:0]        op;
  logic [31:0]       src1;
  logic [31:0]       src2;
  logic              src2_is_imm;
  logic [25:0]       imm;
  logic              rd_valid;
  logic [PREG_W-1:0] rd_index;
  logic [ROB_W-1:0]  rob_index;
  logic              pre_wakeup_valid;
  logic [PREG_W-1:0] pre_wakeup_rd_index;
  logic              wb_valid;
  logic              wb_grant;
  logic              wb_rd_exist;
  logic [PREG_W-1:0] wb_rd_index;
  logic [31:0]       wb_data;
  logic [ROB_W-1:0]  wb_rob_index;

  modport master (
    output flush, issue_valid, op, src1, src2, src2_is_imm, imm,
           rd_valid, rd_index, rob_index, wb_grant,
    input  fu_ready, pre_wakeup_valid, pre_wakeup_rd_index,
           wb_valid, wb_rd_exist, wb_rd_index, wb_data, wb_rob_index
  );

  modport slave (
    input  flush, issue_valid, op, src1, src2, src2_is_imm, imm,
           rd_valid, rd_index, rob_index, wb_grant,
    output fu_ready, pre_wakeup_valid, pre_wakeup_rd_index,
           wb_valid, wb_rd_exist, wb_rd_index, wb_data, wb_rob_index
  );
endinterface

// File: rtl/simple_alu_exec.sv
// Single-cycle integer ALU with a 2-entry result FIFO feeding write-back.
// The result is computed combinationally at issue and queued. The head is
// presented to the write-back arbiter and popped on grant.
// Optional feature macro: SIMPLE_ALU_MUL_EN enables op 12 (32-bit MUL, low
// half). Without it, no multiplier is built and op 12 returns 0.
module simple_alu_exec #(
  parameter int PREG_W = 6,
  parameter int ROB_W  = 6
) (
  input logic              clk,
  input logic              rst,
  simple_alu_exec_if.slave alu
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOR   = 4'd5,
    OP_SLL   = 4'd6,
    OP_SRL   = 4'd7,
    OP_SRA   = 4'd8,
    OP_SLT   = 4'd9,
    OP_SLTU  = 4'd10,
    OP_LU12I = 4'd11,
    OP_MUL   = 4'd12
  } alu_op_e;

  typedef struct packed {
    logic              rd_exist;
    logic [PREG_W-1:0] rd_index;
    logic [ROB_W-1:0]  rob_index;
    logic [31:0]       data;
  } entry_t;

  logic [31:0] opnd_b;
  logic [31:0] result;
  entry_t      new_entry;
  entry_t      head;
  entry_t      mem_q [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        accept;
  logic        pop;
  logic        unused_imm_hi;

  // Only imm[19:0] is consumed (LU12I and the 12-bit immediate).
  assign unused_imm_hi = ^alu.imm[25:20];

  assign opnd_b = alu.src2_is_imm ? {{20{alu.imm[11]}}, alu.imm[11:0]} : alu.src2;

  // Combinational ALU result for the instruction currently presented.
  always_comb begin
    // NOTE: result gets a default before the case so no path leaves it
    // unassigned; otherwise undecoded ops would infer a latch.
    result = '0;
    case (alu_op_e'(alu.op))
      OP_ADD:   result = alu.src1 + opnd_b;
      OP_SUB:   result = alu.src1 - opnd_b;
      OP_AND:   result = alu.src1 & opnd_b;
      OP_OR:    result = alu.src1 | opnd_b;
      OP_XOR:   result = alu.src1 ^ opnd_b;
      OP_NOR:   result = ~(alu.src1 | opnd_b);
      OP_SLL:   result = alu.src1 << opnd_b[4:0];
      OP_SRL:   result = alu.src1 >> opnd_b[4:0];
      OP_SRA:   result = $unsigned($signed(alu.src1) >>> opnd_b[4:0]);
      OP_SLT:   result = {31'b0, $signed(alu.src1) < $signed(opnd_b)};
      OP_SLTU:  result = {31'b0, alu.src1 < opnd_b};
      OP_LU12I: result = {alu.imm[19:0], 12'b0};
`ifdef SIMPLE_ALU_MUL_EN
      OP_MUL:   result = alu.src1 * opnd_b;
`else
      OP_MUL:   result = '0;
`endif
      default:  result = '0;
    endcase
  end

  // A grant on a full FIFO frees the head this cycle, so a new issue fits.
  assign alu.fu_ready = (count_q != 2'd2) || alu.wb_grant;
  assign accept       = alu.issue_valid && alu.fu_ready && !alu.flush;
  assign pop          = (count_q != 2'd0) && alu.wb_grant && !alu.flush;

  assign new_entry.rd_exist  = alu.rd_valid && (alu.rd_index != '0);
  assign new_entry.rd_index  = alu.rd_index;
  assign new_entry.rob_index = alu.rob_index;
  assign new_entry.data      = result;

  // Next FIFO pointers and occupancy; flush empties the queue.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (alu.flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (accept) wr_ptr_d = ~wr_ptr_q;
      if (pop)    rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(accept) - 2'(pop);
    end
  end

  // FIFO control state; reset discards all entries immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write on acceptance.
  // NOTE: payload storage has no reset; count_q alone decides validity,
  // so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= new_entry;
  end

  // On a full FIFO with push and pop, wr_ptr equals rd_ptr. The head is read
  // out this cycle and overwritten at the edge, which preserves order.
  assign head = mem_q[rd_ptr_q];

  assign alu.wb_valid     = (count_q != 2'd0);
  assign alu.wb_rd_exist  = head.rd_exist;
  assign alu.wb_rd_index  = head.rd_index;
  assign alu.wb_rob_index = head.rob_index;
  assign alu.wb_data      = head.data;

  // The result is pre-woken when it will be the head on the next cycle.
  assign alu.pre_wakeup_valid = !rst && accept && new_entry.rd_exist &&
                                ((count_q == 2'd0) ||
                                 ((count_q == 2'd1) && alu.wb_grant));
  assign alu.pre_wakeup_rd_index = alu.rd_index;

endmodule

// File: tb/tb_simple_alu_exec.sv
// Directed and randomized bench for simple_alu_exec with a scoreboard queue.
module tb_simple_alu_exec;

  localparam int PW = 6;
  localparam int RW = 6;

  typedef struct packed {
    logic          rd_exist;
    logic [PW-1:0] rd_index;
    logic [RW-1:0] rob_index;
    logic [31:0]   data;
  } wb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simple_alu_exec_if #(.PREG_W(PW), .ROB_W(RW)) bus ();

  simple_alu_exec #(.PREG_W(PW), .ROB_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .alu (bus)
  );

  wb_t sb[$];
  wb_t pend;
  int  vectors     = 0;
  int  miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] s2, input logic is_imm,
                                          input logic [25:0] imm);
    logic [31:0] b;
    logic [63:0] prod;
    b = is_imm ? {{20{imm[11]}}, imm[11:0]} : s2;
    prod = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + ~b + 32'd1;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return a << b[4:0];
      4'd7:  return a >> b[4:0];
      4'd8:  return (a >> b[4:0]) | (a[31] ? ~(32'hFFFF_FFFF >> b[4:0]) : 32'd0);
      4'd9:  return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      4'd10: return {31'b0, a < b};
      4'd11: return {imm[19:0], 12'h000};
`ifdef SIMPLE_ALU_MUL_EN
      4'd12: return prod[31:0];
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Present an instruction and stage its expected write-back record.
  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] s1,
                       input logic [31:0] s2, input logic is_imm, input logic [25:0] imm,
                       input logic rdv, input logic [PW-1:0] rd, input logic [RW-1:0] rob,
                       input logic [31:0] exp_data);
    bus.issue_valid = v;
    bus.op          = op;
    bus.src1        = s1;
    bus.src2        = s2;
    bus.src2_is_imm = is_imm;
    bus.imm         = imm;
    bus.rd_valid    = rdv;
    bus.rd_index    = rd;
    bus.rob_index   = rob;
    pend.rd_exist   = rdv && (rd != 0);
    pend.rd_index   = rd;
    pend.rob_index  = rob;
    pend.data       = exp_data;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 26'd0, 1'b0, '0, '0, 32'd0);
  endtask

  // Check one cycle at the negedge, then advance the scoreboard past the posedge.
  task automatic cycle(input string tag);
    logic exp_ready, exp_acc, exp_pw;
    @(negedge clk);
    exp_ready = (sb.size() < 2) || bus.wb_grant;
    exp_acc   = bus.issue_valid && exp_ready && !bus.flush;
    exp_pw    = exp_acc && bus.rd_valid && (bus.rd_index != 0) &&
                ((sb.size() == 0) || ((sb.size() == 1) && bus.wb_grant));
    chk({tag, ".fu_ready"}, {31'b0, bus.fu_ready}, {31'b0, exp_ready});
    chk({tag, ".pre_wakeup"}, {31'b0, bus.pre_wakeup_valid}, {31'b0, exp_pw});
    if (exp_pw)
      chk({tag, ".pre_wakeup_idx"}, 32'(bus.pre_wakeup_rd_index), 32'(bus.rd_index));
    chk({tag, ".wb_valid"}, {31'b0, bus.wb_valid}, {31'b0, sb.size() != 0});
    if (sb.size() != 0) begin
      chk({tag, ".wb_data"}, bus.wb_data, sb[0].data);
      chk({tag, ".wb_rd_exist"}, {31'b0, bus.wb_rd_exist}, {31'b0, sb[0].rd_exist});
      chk({tag, ".wb_rob"}, 32'(bus.wb_rob_index), 32'(sb[0].rob_index));
      if (sb[0].rd_exist)
        chk({tag, ".wb_rd"}, 32'(bus.wb_rd_index), 32'(sb[0].rd_index));
    end
    @(posedge clk);
    #1;
    if (bus.flush) sb.delete();
    else begin
      if (bus.wb_grant && sb.size() != 0) void'(sb.pop_front());
      if (exp_acc) sb.push_back(pend);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, e;
    logic [3:0]  op;
    logic [25:0] imm;
    logic        im;

    // Reset state, with an issue presented so pre-wakeup gating is exercised.
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.wb_grant = 1'b0;
    drive(1'b1, 4'd0, 32'd1, 32'd1, 1'b0, 26'd0, 1'b1, 6'd5, 6'd0, 32'd2);
    #3;
    chk("rst.fu_ready", {31'b0, bus.fu_ready}, 32'd1);
    chk("rst.wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    chk("rst.pre_wakeup", {31'b0, bus.pre_wakeup_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // ADD with pre-wakeup at T and write-back at T+1.
    bus.wb_grant = 1'b1;
    drive(1'b1, 4'd0, 32'd5, 32'd7, 1'b0, 26'd0, 1'b1, 6'd3, 6'd1, 32'd12);
    cycle("add");
    idle();
    cycle("add_wb");

    // Back-to-back ADDI, SRA, SLTU with continuous grant.
    drive(1'b1, 4'd0, 32'h10, 32'd0, 1'b1, 26'h0000FFF, 1'b1, 6'd4, 6'd2, 32'h0000000F);
    cycle("addi");
    drive(1'b1, 4'd8, 32'h80000000, 32'd4, 1'b0, 26'd0, 1'b1, 6'd5, 6'd3, 32'hF8000000);
    cycle("sra");
    drive(1'b1, 4'd10, 32'd1, 32'hFFFFFFFF, 1'b0, 26'd0, 1'b1, 6'd6, 6'd4, 32'd1);
    cycle("sltu");
    idle();
    cycle("drain0");

    // Backpressure: three issues without grant; the third is held.
    bus.wb_grant = 1'b0;
    drive(1'b1, 4'd1, 32'd100, 32'd1, 1'b0, 26'd0, 1'b1, 6'd7, 6'd5, 32'd99);
    cycle("bp_a");
    drive(1'b1, 4'd3, 32'hF0, 32'h0F, 1'b0, 26'd0, 1'b1, 6'd8, 6'd6, 32'hFF);
    cycle("bp_b");
    drive(1'b1, 4'd11, 32'd0, 32'd0, 1'b0, 26'h0012345, 1'b1, 6'd9, 6'd7, 32'h12345000);
    cycle("bp_c_held");
    chk("bp.depth", 32'(sb.size()), 32'd2);
    // Full with simultaneous push and pop.
    bus.wb_grant = 1'b1;
    cycle("bp_c_pushpop");
    chk("bp.depth_after", 32'(sb.size()), 32'd2);
    idle();
    cycle("bp_drain1");
    cycle("bp_drain2");

    // Destination register 0 completes without pre-wakeup or rd_exist.
    drive(1'b1, 4'd2, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 26'd0, 1'b1, 6'd0, 6'd8, 32'h0F000F00);
    cycle("rd0");
    idle();
    cycle("rd0_wb");

    // Flush with a full FIFO and an issue presented.
    bus.wb_grant = 1'b0;
    drive(1'b1, 4'd4, 32'hAAAA5555, 32'hFFFF0000, 1'b0, 26'd0, 1'b1, 6'd10, 6'd9, 32'h55555555);
    cycle("fl_a");
    drive(1'b1, 4'd5, 32'h0, 32'h0, 1'b0, 26'd0, 1'b1, 6'd11, 6'd10, 32'hFFFFFFFF);
    cycle("fl_b");
    bus.flush    = 1'b1;
    bus.wb_grant = 1'b1;
    drive(1'b1, 4'd0, 32'd1, 32'd2, 1'b0, 26'd0, 1'b1, 6'd12, 6'd11, 32'd3);
    cycle("flush");
    bus.flush    = 1'b0;
    bus.wb_grant = 1'b0;
    idle();
    cycle("post_flush");

    // Randomized ops with random grant and occasional flush.
    for (int i = 0; i < 60; i++) begin
      op  = 4'($urandom_range(0, 15));
      a   = $urandom();
      b   = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      im  = 1'($urandom_range(0, 1));
      imm = 26'($urandom());
      e   = alu_ref(op, a, b, im, imm);
      drive(1'($urandom_range(0, 3) != 0), op, a, b, im, imm, 1'($urandom_range(0, 1)),
            PW'($urandom_range(0, 3)), RW'(i), e);
      bus.wb_grant = 1'($urandom_range(0, 2) != 0);
      bus.flush    = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end
    bus.flush    = 1'b0;
    bus.wb_grant = 1'b1;
    idle();
    cycle("rand_drain1");
    cycle("rand_drain2");

    // Asynchronous reset mid-stream discards entries at once.
    bus.wb_grant = 1'b0;
    drive(1'b1, 4'd6, 32'd1, 32'd31, 1'b0, 26'd0, 1'b1, 6'd13, 6'd12, 32'h80000000);
    cycle("pre_rst");
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    chk("rst_mid.fu_ready", {31'b0, bus.fu_ready}, 32'd1);
    sb.delete();
    #1;
    rst = 1'b0;
    cycle("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
